subbytes_iter: RTL and testbench
================================

SUBBYTES_ITER -- requirements
Module: subbytes_iter

Interface
REQ-001 The block SHALL have parameter LANES, default 4, number of parallel byte-substitution lanes; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL fail elaboration for any other LANES value.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a 128-bit state is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a state.
REQ-007 The block SHALL have port data, input, 128, the AES state; byte i = data[127-8i -: 8], i = 0..15.
REQ-008 The block SHALL have port inv, input, 1, mode: 0 = forward SubBytes, 1 = InvSubBytes.
REQ-009 The block SHALL have port out_valid, output, 1, meaning s_out holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port s_out, output, 128, the substituted state, same byte order as data.
REQ-012 The block SHALL have port busy, output, 1, high while substitution is in progress.

Function
REQ-013 The block SHALL instantiate exactly LANES forward and LANES inverse S-box lookups, time-multiplexed over the 16 bytes.
REQ-014 The block SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); busy = (state == BUSY); out_valid = (state == DONE).
REQ-015 On in_valid && in_ready at an edge, the block SHALL load data into the working register, latch inv, clear group counter cnt, and enter BUSY.
REQ-016 The block SHALL ignore inv and data changes after acceptance until the next acceptance.
REQ-017 In BUSY, each edge SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 with their substituted values and increment cnt.
REQ-018 cnt SHALL be log2(16/LANES) bits wide (1 bit minimum); on the edge processing group 16/LANES-1 the block SHALL enter DONE and cnt SHALL wrap to 0.
REQ-019 out_valid SHALL rise exactly 16/LANES edges after the accepting edge (LANES=4: 4 edges; LANES=16: 1 edge).
REQ-020 In DONE, s_out and out_valid SHALL hold stable until out_ready is high at an edge; the block then returns to IDLE.
REQ-021 The block SHALL accept no new input in BUSY or DONE; in_valid there is ignored and data is not sampled.
REQ-022 Back-to-back throughput SHALL be one state per 16/LANES + 2 cycles with out_ready held high.
REQ-023 s_out SHALL be driven directly from the working register; untouched bytes are never visible in DONE.

Reset
REQ-024 While rst is high, state SHALL be IDLE, cnt = 0, working register = 0, latched mode = 0.
REQ-025 Reset outputs SHALL be in_ready = 1, out_valid = 0, busy = 0, s_out = 128'h0.
REQ-026 rst asserted in BUSY or DONE SHALL abort immediately, asynchronously; the partial result is discarded and never presented.
REQ-027 After rst deasserts, the first edge with in_valid high SHALL be accepted normally.

Verification
REQ-028 LANES=4, inv=0, data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid after 4 edges, s_out=d42711aee0bf98f1b8b45de51e415230.
REQ-029 LANES=1 and LANES=16, inv=1, data=d42711aee0bf98f1b8b45de51e415230 -> s_out=193de3bea0f4e22b9ac68d2ae9f84808 after 16 and 1 edges respectively.
REQ-030 Forward, data all 00 -> s_out all 63; data all 53 -> s_out all ed; inverse of all 63 -> all 00.
REQ-031 Backpressure: out_ready low 10 cycles in DONE -> s_out, out_valid stable, in_ready low, in_valid pulses with other data ignored; out_ready high -> IDLE next edge.
REQ-032 rst pulsed mid-BUSY (LANES=2, cnt=3) -> out_valid 0, s_out 0 at once; next accepted state yields a correct result only.
REQ-033 inv toggled and data changed during BUSY -> result matches mode and data latched at acceptance.

Source files
------------

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes/InvSubBytes over a 128-bit state,
// LANES bytes substituted per cycle with a valid/ready handshake.
module subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] s_out,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LW     = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_work;
    logic [127:0]    w_work_n;
    logic            r_inv;
    logic [3:0]      w_base;
    logic [6:0]      w_pos [LANES];
    logic [7:0]      w_sub [LANES];

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
               {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^
            {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign w_base = 4'(r_cnt) << LW;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] w_byte;
        logic [7:0] w_fwd;
        logic [7:0] w_inv;
        assign w_pos[j] = {4'd15 - (w_base + 4'(j)), 3'b000};
        assign w_byte   = r_work[w_pos[j] +: 8];
        assign w_fwd    = fwd_sbox(w_byte);
        assign w_inv    = inv_sbox(w_byte);
        assign w_sub[j] = r_inv ? w_inv : w_fwd;
    end

    always_comb begin
        w_work_n = r_work;
        for (int j = 0; j < LANES; j++) begin
            w_work_n[w_pos[j] +: 8] = w_sub[j];
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_n = BUSY;
            BUSY:    if (r_cnt == LAST) w_state_n = DONE;
            DONE:    if (out_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= data;
                        r_inv  <= inv;
                        r_cnt  <= '0;
                    end
                end
                BUSY: begin
                    r_work <= w_work_n;
                    r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == BUSY);
    assign out_valid = (r_state == DONE);
    assign s_out     = r_work;

endmodule

// File: tb/tb_subbytes_iter.sv
// Scoreboard bench: four subbytes_iter instances (LANES 1,2,4,16)
// share stimulus; a table-driven S-box model predicts every result.
module tb_subbytes_iter;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [127:0] d;
        int           acc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] data = '0;
    logic         inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   rdy;
    logic [3:0]   ov;
    logic [3:0]   bsy;
    logic [127:0] so [4];

    logic [7:0]   fsb [256];
    logic [7:0]   isb [256];
    ent_t         sb [4][$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d,
                                           input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[127-8*i -: 8];
            r[127-8*i -: 8] = m ? isb[b] : fsb[b];
        end
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 :
                           (g == 2) ? 4 : 16;
        logic prev = 1'b0;
        ent_t e;

        subbytes_iter #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .data      (data),
            .inv       (inv),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .s_out     (so[g]),
            .busy      (bsy[g])
        );

        always @(negedge clk) begin
            if (!rst) begin
                if (in_valid && rdy[g])
                    sb[g].push_back(ent_t'{model(data, inv), cyc + 1});
                if (ov[g] && !prev && sb[g].size() > 0)
                    check($sformatf("latency_L%0d", L),
                          128'(cyc - sb[g][0].acc), 128'(16 / L));
                if (ov[g] && out_ready) begin
                    if (sb[g].size() == 0) begin
                        check($sformatf("unexpected_L%0d", L), 1, 0);
                    end else begin
                        e = sb[g].pop_front();
                        check($sformatf("s_out_L%0d", L), so[g], e.d);
                    end
                end
            end
            prev <= ov[g];
        end
    end

    task automatic wait_all_ready();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (&rdy) break;
            n++;
            if (n > 300) begin
                check("ready_timeout", 128'(rdy), 128'hf);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (sb[0].size() == 0 && sb[1].size() == 0 &&
                sb[2].size() == 0 && sb[3].size() == 0 && &rdy) break;
            n++;
            if (n > 300) begin
                check("idle_timeout", 128'(rdy), 128'hf);
                break;
            end
        end
    endtask

    // drop in_valid after acceptance and scramble data/inv meanwhile
    task automatic send(input logic [127:0] d, input logic m);
        wait_all_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data     = d;
        inv      = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data     = {$urandom, $urandom, $urandom, $urandom};
        inv      = ~m;
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) sb[k].delete();
    endtask

    initial begin
        logic [2047:0] t;
        logic [127:0]  snap;
        int            acc_q[$];
        t = SBOX;
        for (int i = 0; i < 256; i++) begin
            fsb[i]      = t[2047-8*i -: 8];
            isb[fsb[i]] = i[7:0];
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(rdy), 128'hf);
        check("rst_out_valid", 128'(ov), 128'h0);
        check("rst_busy", 128'(bsy), 128'h0);
        for (int k = 0; k < 4; k++)
            check($sformatf("rst_s_out_%0d", k), so[k], 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        wait_idle();
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1);
        wait_idle();
        send({16{8'h00}}, 1'b0);
        send({16{8'h53}}, 1'b0);
        send({16{8'h63}}, 1'b1);
        for (int i = 0; i < 6; i++)
            send({$urandom, $urandom, $urandom, $urandom}, i[0]);
        wait_idle();

        out_ready = 1'b0;
        send(128'h00112233445566778899aabbccddeeff, 1'b0);
        repeat (20) @(negedge clk);
        snap = so[2];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            data     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", 128'(ov), 128'hf);
            check("bp_s_out", so[2], snap);
            check("bp_in_ready", 128'(rdy), 128'h0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 128'(rdy), 128'hf);
        check("bp_release_valid", 128'(ov), 128'h0);
        wait_idle();

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        inv      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[2]) acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("tput_count", 128'(acc_q.size() >= 6), 128'h1);
        for (int i = 1; i < acc_q.size(); i++)
            check("tput_period", 128'(acc_q[i] - acc_q[i-1]), 128'd6);
        wait_idle();

        send(128'hffeeddccbbaa99887766554433221100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy_L2", 128'(bsy[1]), 128'h1);
        rst = 1'b1;
        #1;
        flush();
        check("abort_out_valid", 128'(ov), 128'h0);
        check("abort_s_out_L2", so[1], 128'h0);
        check("abort_busy", 128'(bsy), 128'h0);
        check("abort_in_ready", 128'(rdy), 128'hf);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        wait_idle();

        for (int k = 0; k < 4; k++)
            check($sformatf("sb_empty_%0d", k), 128'(sb[k].size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
